mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one synchronous single-port memory between the CPU instruction-fetch port (I) and the data load/store port (D) in the multi-cycle build of the core. It accepts one transaction at a time and alternates ownership under contention. It drives the memory's command signals and returns read data to the owning port with a one-cycle valid pulse. It also lets the exception/redirect logic cancel an in-flight fetch.

## Interface
- LAT, 1, memory read latency in cycles; legal range 1..4.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high, with i_addr stable, until i_gnt.
- i_addr  in  32  fetch byte address.
- i_kill  in  1  cancel outstanding fetch response.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  fetched word, registered.
- d_req  in  1  data request; held, with d_* stable, until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  byte enables for stores.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- d_rdata  out  32  load word, registered.
- m_en  out  1  memory command strobe.
- m_we  out  1  memory write.
- m_be  out  4  memory byte enables.
- m_addr  out  32  memory word address, low 2 bits forced to 0.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data, valid LAT cycles after m_en.
- busy  out  1  transaction outstanding.

## Operation
- **States.** IDLE and BUSY. Internal registers:
  - cnt, 3 bits.
  - owner, 1 bit: 0 = I, 1 = D.
  - last, 1 bit: the owner of the previous grant.
  - kill_pend, 1 bit.
- **Arbitration in IDLE.**
  - Only d_req high: D wins.
  - Only i_req high: I wins.
  - Both high: the port not equal to last wins.
  - last resets to I, so D wins the first contention after reset.
- **Grant cycle.** Combinational in IDLE. In the same cycle:
  - Pulse the winner's gnt.
  - m_en = 1, with m_addr, m_we, m_be, m_wdata from the winner.
  - Fetches drive m_we = 0 and m_be = 4'hF.
  - Load owner and last with the winner; cnt = LAT; go to BUSY.
- **BUSY.**
  - m_en = 0 and both gnt outputs = 0, regardless of requests.
  - cnt decrements each cycle.
  - In the cycle with cnt == 1: capture m_rdata into the owner's rdata register (loads and fetches only), set that port's rvalid for the next cycle, and go to IDLE.
- **Stores.** d_rvalid still pulses at the same position. d_rdata is unchanged.
- **i_kill.**
  - Sampled every cycle, including the grant cycle.
  - If asserted while owner = I, or in the grant cycle of an I win, set kill_pend.
  - At completion, a pending kill suppresses the i_rvalid pulse, and i_rdata is not updated. kill_pend clears at completion.
  - i_kill has no effect on D transactions or when idle.
- **busy** = (state == BUSY).
- **No request queueing.** A request arriving during BUSY waits. The requester must hold it.

## Timing
- Grant at cycle T. BUSY during T+1 .. T+LAT. rvalid high during T+LAT+1.
- The arbiter is IDLE again in T+LAT+1, so a new grant may coincide with the rvalid pulse.
- Peak throughput is one transaction per LAT+1 cycles. Under continuous contention, grants alternate D, I, D, I, …
- Reset values, all asserted asynchronously on reset rising:
  - state = IDLE, cnt = 0, owner = I, last = I, kill_pend = 0.
  - i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, busy = 0.
  - m_be = 0, i_rdata = 0, d_rdata = 0.
  - m_addr and m_wdata = 0 while idle with no request.
- Reset mid-transaction:
  - The outstanding response is dropped; no rvalid follows.
  - Memory output returning after reset is ignored.
- Behaviour when the requester drops req before gnt is allowed: no grant is issued. Changing addr before gnt is the requester's fault and is not checked.
- LAT outside 1..4 is unsupported.

## Test plan
- **Single load, LAT=1.**
  - Stimulus: d_req=1, d_we=0, d_addr=0x1006, memory returns 0xCAFEF00D.
  - Required: d_gnt and m_en at T with m_addr=0x1004; busy at T+1; d_rvalid at T+2 with d_rdata=0xCAFEF00D.
- **Contention, LAT=2.**
  - Stimulus: i_req and d_req held high for 12 cycles.
  - Required: grants at T, T+3, T+6, T+9 in order D, I, D, I; each rvalid lands 3 cycles after its grant on the matching port.
- **Store.**
  - Stimulus: d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0x12345678.
  - Required: m_we=1, m_be=0011, m_wdata=0x12345678 in the grant cycle; d_rvalid at T+LAT+1; d_rdata unchanged.
- **Back-to-back fetches, LAT=1.**
  - Stimulus: i_req held high.
  - Required: grants every 2 cycles; i_rvalid of fetch n coincides with i_gnt of fetch n+1.
- **Kill.**
  - Stimulus: i_kill pulsed at T+1 of a fetch (LAT=3).
  - Required: no i_rvalid at T+4 and i_rdata unchanged; a D request pending at T+4 is granted that cycle.
- **Reset mid-op.**
  - Stimulus: reset asserted at T+1 of a LAT=4 load.
  - Required: busy, m_en and d_rvalid drop immediately; no d_rvalid ever appears for that load; the first request after release is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter for a shared synchronous memory
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_kill,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [3:0]  m_be,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic        owner;      // 0 = fetch port, 1 = data port
  logic        last;       // owner of the previous grant
  logic        kill_pend;
  logic        store_q;    // current D transaction is a store
  logic        grant_i, grant_d;
  logic        done;

  // Arbitration, memory command and next-state decode
  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    state_nxt = state;
    done      = 1'b0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_be      = 4'h0;
    m_addr    = 32'h0;
    m_wdata   = 32'h0;
    busy      = (state == BUSY);

    // Grants are held off while reset is high so no command escapes during reset.
    if (state == IDLE && !reset) begin
      if (i_req && d_req) begin
        grant_i = last;
        grant_d = !last;
      end else begin
        grant_d = d_req;
        grant_i = i_req && !d_req;
      end
    end

    case (state)
      IDLE: if (grant_i || grant_d) state_nxt = BUSY;
      BUSY: begin
        done = (cnt == 3'd1);
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    i_gnt = grant_i;
    d_gnt = grant_d;
    m_en  = grant_i || grant_d;
    if (grant_d) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr & 32'hFFFF_FFFC;
      m_wdata = d_wdata;
    end else if (grant_i) begin
      m_be    = 4'hF;
      m_addr  = i_addr & 32'hFFFF_FFFC;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Transaction bookkeeping: latency counter, ownership and pending kill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 3'd0;
      owner     <= 1'b0;
      last      <= 1'b0;
      kill_pend <= 1'b0;
      store_q   <= 1'b0;
    end else if (grant_i || grant_d) begin
      cnt       <= 3'(LAT);
      owner     <= grant_d;
      last      <= grant_d;
      store_q   <= grant_d && d_we;
      kill_pend <= grant_i && i_kill;
    end else if (state == BUSY) begin
      cnt <= cnt - 3'd1;
      if (done)
        kill_pend <= 1'b0;
      else if (!owner && i_kill)
        kill_pend <= 1'b1;
    end
  end

  // Response capture and one-cycle valid pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rvalid <= 1'b0;
      i_rdata  <= 32'h0;
      d_rvalid <= 1'b0;
      d_rdata  <= 32'h0;
    end else begin
      // A kill arriving in the completion cycle itself is honoured too.
      i_rvalid <= done && !owner && !(kill_pend || i_kill);
      d_rvalid <= done && owner;
      if (done && !owner && !(kill_pend || i_kill))
        i_rdata <= m_rdata;
      if (done && owner && !store_q)
        d_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at LAT 1..4
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_kill, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;

  logic [3:0]  i_gnt_v, i_rvalid_v, d_gnt_v, d_rvalid_v, m_en_v, m_we_v, busy_v;
  logic [31:0] i_rdata_v [4];
  logic [31:0] d_rdata_v [4];
  logic [31:0] m_addr_v  [4];
  logic [31:0] m_wdata_v [4];
  logic [3:0]  m_be_v    [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_arbiter #(.LAT(g + 1)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_kill   (i_kill),
      .i_gnt    (i_gnt_v[g]),
      .i_rvalid (i_rvalid_v[g]),
      .i_rdata  (i_rdata_v[g]),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_be     (d_be),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt_v[g]),
      .d_rvalid (d_rvalid_v[g]),
      .d_rdata  (d_rdata_v[g]),
      .m_en     (m_en_v[g]),
      .m_we     (m_we_v[g]),
      .m_be     (m_be_v[g]),
      .m_addr   (m_addr_v[g]),
      .m_wdata  (m_wdata_v[g]),
      .m_rdata  (m_rdata),
      .busy     (busy_v[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start a new cycle: inputs driven here are seen before the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req = 0; i_kill = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1;
    clear_inputs();
    cyc();
    cyc();
    reset = 0;
  endtask

  initial begin
    logic [3:0] obs, exp4;
    logic       seen;
    reset = 1;
    clear_inputs();
    m_rdata = 32'h0;

    // Reset state, with both requests raised to show no grant leaks out
    cyc();
    i_req = 1; d_req = 1; i_addr = 32'h44; d_addr = 32'h88; d_wdata = 32'h99;
    @(negedge clk);
    check("rst_gnt",   {30'd0, i_gnt_v[0], d_gnt_v[0]}, 32'h0);
    check("rst_m_en",  {31'd0, m_en_v[0]}, 32'h0);
    check("rst_m_be",  {28'd0, m_be_v[0]}, 32'h0);
    check("rst_busy",  {31'd0, busy_v[0]}, 32'h0);
    do_reset();
    @(negedge clk);
    check("idle_m_addr",  m_addr_v[0], 32'h0);
    check("idle_m_wdata", m_wdata_v[0], 32'h0);
    check("idle_rdata",   i_rdata_v[0] | d_rdata_v[0], 32'h0);
    check("idle_rvalid",  {30'd0, i_rvalid_v[0], d_rvalid_v[0]}, 32'h0);

    // Single load, LAT=1
    cyc();
    d_req = 1; d_we = 0; d_addr = 32'h1006;
    @(negedge clk);
    check("ld_gnt",    {29'd0, d_gnt_v[0], i_gnt_v[0], m_en_v[0]}, 32'h5);
    check("ld_m_addr", m_addr_v[0], 32'h1004);
    check("ld_m_we",   {31'd0, m_we_v[0]}, 32'h0);
    cyc();
    d_req = 0; m_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("ld_busy",   {30'd0, busy_v[0], m_en_v[0]}, 32'h2);
    check("ld_early",  {31'd0, d_rvalid_v[0]}, 32'h0);
    cyc();
    @(negedge clk);
    check("ld_rvalid", {30'd0, d_rvalid_v[0], busy_v[0]}, 32'h2);
    check("ld_rdata",  d_rdata_v[0], 32'hCAFEF00D);
    cyc();
    @(negedge clk);
    check("ld_pulse",  {31'd0, d_rvalid_v[0]}, 32'h0);

    // Contention, LAT=2: D, I, D, I every 3 cycles
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      cyc();
      i_req = (k < 12); d_req = (k < 12);
      i_addr = 32'h400; d_addr = 32'h800; d_we = 0;
      @(negedge clk);
      obs  = {i_gnt_v[1], d_gnt_v[1], i_rvalid_v[1], d_rvalid_v[1]};
      exp4 = 4'b0000;
      if (k % 3 == 0) begin
        if (k < 12) exp4[3:2] = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
        if (k >= 3) exp4[1:0] = (((k / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10;
      end
      check($sformatf("cont_k%0d", k), {28'd0, obs}, {28'd0, exp4});
    end

    // Store, LAT=2
    do_reset();
    cyc();
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(negedge clk);
    check("st_gnt",    {30'd0, d_gnt_v[1], m_we_v[1]}, 32'h3);
    check("st_m_be",   {28'd0, m_be_v[1]}, 32'h3);
    check("st_m_wdat", m_wdata_v[1], 32'h12345678);
    check("st_m_addr", m_addr_v[1], 32'h20);
    cyc();
    d_req = 0; d_we = 0; m_rdata = 32'hDEADBEEF;
    cyc();
    @(negedge clk);
    check("st_early",  {31'd0, d_rvalid_v[1]}, 32'h0);
    cyc();
    @(negedge clk);
    check("st_rvalid", {31'd0, d_rvalid_v[1]}, 32'h1);
    check("st_rdata",  d_rdata_v[1], 32'h0);

    // Back-to-back fetches, LAT=1
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      cyc();
      i_req  = (k < 6);
      i_addr = 32'h200 + 32'(4 * (k / 2)) + 32'h2;
      m_rdata = 32'h100 + 32'(k);
      @(negedge clk);
      check($sformatf("b2b_gnt_k%0d", k), {31'd0, i_gnt_v[0]}, {31'd0, (k < 6) && (k % 2 == 0)});
      check($sformatf("b2b_rv_k%0d", k),  {31'd0, i_rvalid_v[0]}, {31'd0, (k >= 2) && (k % 2 == 0)});
      if (k < 6 && k % 2 == 0)
        check($sformatf("b2b_addr_k%0d", k), m_addr_v[0], 32'h200 + 32'(4 * (k / 2)));
      if (k >= 2 && k % 2 == 0)
        check($sformatf("b2b_data_k%0d", k), i_rdata_v[0], 32'h100 + 32'(k - 1));
    end

    // Kill, LAT=3
    do_reset();
    cyc();
    i_req = 1; i_addr = 32'h40; m_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("kill_gnt", {31'd0, i_gnt_v[2]}, 32'h1);
    cyc();
    i_req = 0; i_kill = 1;
    cyc();
    i_kill = 0;
    cyc();
    d_req = 1; d_we = 0; d_addr = 32'h80;
    @(negedge clk);
    check("kill_dwait", {30'd0, d_gnt_v[2], busy_v[2]}, 32'h1);
    cyc();
    @(negedge clk);
    check("kill_rvalid", {31'd0, i_rvalid_v[2]}, 32'h0);
    check("kill_rdata",  i_rdata_v[2], 32'h0);
    check("kill_dgnt",   {30'd0, d_gnt_v[2], m_en_v[2]}, 32'h3);
    cyc();
    d_req = 0;

    // Reset mid-op, LAT=4
    do_reset();
    cyc();
    d_req = 1; d_we = 0; d_addr = 32'h300;
    @(negedge clk);
    check("rmid_gnt", {31'd0, d_gnt_v[3]}, 32'h1);
    cyc();
    d_req = 0; m_rdata = 32'hBAD0BAD0;
    check("rmid_busy", {31'd0, busy_v[3]}, 32'h1);
    reset = 1;
    #1;
    check("rmid_drop", {29'd0, busy_v[3], m_en_v[3], d_rvalid_v[3]}, 32'h0);
    cyc();
    reset = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      seen = seen | d_rvalid_v[3];
    end
    check("rmid_no_rvalid", {31'd0, seen}, 32'h0);
    cyc();
    d_req = 1; d_addr = 32'h304; m_rdata = 32'h0BADF00D;
    @(negedge clk);
    check("rmid_regnt", {30'd0, d_gnt_v[3], m_en_v[3]}, 32'h3);
    cyc();
    d_req = 0;
    for (int k = 0; k < 4; k++) cyc();
    @(negedge clk);
    check("rmid_rvalid", {31'd0, d_rvalid_v[3]}, 32'h1);
    check("rmid_rdata",  d_rdata_v[3], 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
